// File: rtl/adaptor_pic_spi_responder.sv
// adaptor_pic_spi_responder
// FPGA-side SPI responder standing in for the adaptor-board PIC. An initiator
// frames 16-bit transfers with CS low. This block captures DI on SC falling
// edges and shifts the response word out on DO after SC rising edges. All
// inputs are asynchronous and are synchronised onto i_clk.
//
// Ports
//   i_clk        system clock (125 MHz)
//   i_rst        synchronous reset, active high
//   i_PIC_SC     SPI serial clock from the initiator (async)
//   i_PIC_CS     SPI chip select, active low (async)
//   i_PIC_DI     SPI data from the initiator (async)
//   o_PIC_DO     SPI data to the initiator
//   i_tx_data    response word, latched at frame start
//   o_rx_data    last correctly framed received word
//   o_rx_valid   one-cycle pulse when o_rx_data updates
//   o_frame_err  one-cycle pulse on a short or over-length frame
//   o_busy       high while a frame is in progress
//
// Build option
//   ADAPTOR_PIC_SPI_RESPONDER_FILTER_EN  adds a FILTER_CYCLES level filter on
//                                        the synchronised SC and CS.
module adaptor_pic_spi_responder #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_PIC_SC,
    input  logic                  i_PIC_CS,
    input  logic                  i_PIC_DI,
    output logic                  o_PIC_DO,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_frame_err,
    output logic                  o_busy
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Bit counter saturates one past a full frame so over-length is visible.
    localparam int unsigned CNT_W   = $clog2(DATA_WIDTH + 2);
    localparam int unsigned CNT_MAX = DATA_WIDTH + 1;

    // Cycles after reset before the CS level reflects real pin samples. The
    // span is long enough for the filtered build too.
    localparam int unsigned WARM_CYCLES = SYNC_STAGES + FILTER_CYCLES + 1;
    localparam int unsigned WARM_W      = $clog2(WARM_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sc_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] di_sync;
    logic                   sc_lvl;
    logic                   cs_lvl;
    logic                   sc_lvl_d;
    logic                   cs_lvl_d;
    logic                   di_bit;
    logic                   sc_fall;
    logic                   sc_rise;
    logic                   cs_fall;
    logic                   cs_rise;
    logic [WARM_W-1:0]      warm_cnt;
    logic                   warm_done;
    logic                   cs_armed;

    logic [0:0]             state_q;
    logic [0:0]             state_d;
    logic [DATA_WIDTH-2:0]  tx_rem_q;
    logic [DATA_WIDTH-2:0]  tx_rem_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q;
    logic [DATA_WIDTH-1:0]  rx_shift_d;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [CNT_W-1:0]       bit_cnt_d;
    logic                   do_d;
    logic [DATA_WIDTH-1:0]  rx_data_d;
    logic                   rx_valid_d;
    logic                   frame_err_d;
    logic                   busy_d;

    assign di_bit    = di_sync[SYNC_STAGES-1];
    assign warm_done = (warm_cnt == WARM_W'(WARM_CYCLES));

    // Input synchronisers, edge-detect delay copies and CS arming.
    // CS arms only after a genuine high level has been seen, so a CS that is
    // already low when reset releases can never start a frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sc_sync  <= '1;
            cs_sync  <= '1;
            di_sync  <= '0;
            sc_lvl_d <= 1'b1;
            cs_lvl_d <= 1'b1;
            warm_cnt <= '0;
            cs_armed <= 1'b0;
        end else begin
            sc_sync  <= {sc_sync[SYNC_STAGES-2:0], i_PIC_SC};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], i_PIC_CS};
            di_sync  <= {di_sync[SYNC_STAGES-2:0], i_PIC_DI};
            sc_lvl_d <= sc_lvl;
            cs_lvl_d <= cs_lvl;
            if (!warm_done) begin
                warm_cnt <= warm_cnt + WARM_W'(1);
            end
            if (warm_done && cs_lvl && cs_lvl_d) begin
                cs_armed <= 1'b1;
            end
        end
    end

`ifdef ADAPTOR_PIC_SPI_RESPONDER_FILTER_EN
    localparam int unsigned FCNT_W = $clog2(FILTER_CYCLES + 1);

    logic [FCNT_W-1:0] sc_fcnt;
    logic [FCNT_W-1:0] cs_fcnt;
    logic              sc_filt;
    logic              cs_filt;

    // Level filters: a new level is accepted after FILTER_CYCLES consecutive
    // samples that disagree with the current filtered level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sc_fcnt <= '0;
            cs_fcnt <= '0;
            sc_filt <= 1'b1;
            cs_filt <= 1'b1;
        end else begin
            if (sc_sync[SYNC_STAGES-1] == sc_filt) begin
                sc_fcnt <= '0;
            end else if (sc_fcnt == FCNT_W'(FILTER_CYCLES - 1)) begin
                sc_filt <= ~sc_filt;
                sc_fcnt <= '0;
            end else begin
                sc_fcnt <= sc_fcnt + FCNT_W'(1);
            end

            if (cs_sync[SYNC_STAGES-1] == cs_filt) begin
                cs_fcnt <= '0;
            end else if (cs_fcnt == FCNT_W'(FILTER_CYCLES - 1)) begin
                cs_filt <= ~cs_filt;
                cs_fcnt <= '0;
            end else begin
                cs_fcnt <= cs_fcnt + FCNT_W'(1);
            end
        end
    end

    assign sc_lvl = sc_filt;
    assign cs_lvl = cs_filt;
`else
    assign sc_lvl = sc_sync[SYNC_STAGES-1];
    assign cs_lvl = cs_sync[SYNC_STAGES-1];
`endif

    assign sc_fall = sc_lvl_d & ~sc_lvl;
    assign sc_rise = ~sc_lvl_d & sc_lvl;
    assign cs_fall = cs_lvl_d & ~cs_lvl;
    assign cs_rise = ~cs_lvl_d & cs_lvl;

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            tx_rem_q    <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            o_PIC_DO    <= 1'b0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_rem_q    <= tx_rem_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            o_PIC_DO    <= do_d;
            o_rx_data   <= rx_data_d;
            o_rx_valid  <= rx_valid_d;
            o_frame_err <= frame_err_d;
            o_busy      <= busy_d;
        end
    end

    // Next-state and output logic. A CS rise takes priority over any SC edge
    // in the same cycle, so that SC edge is dropped.
    always_comb begin
        state_d     = state_q;
        tx_rem_d    = tx_rem_q;
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        do_d        = o_PIC_DO;
        rx_data_d   = o_rx_data;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        busy_d      = o_busy;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall && cs_armed) begin
                    tx_rem_d   = i_tx_data[DATA_WIDTH-2:0];
                    do_d       = i_tx_data[DATA_WIDTH-1];
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH)) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    do_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (sc_fall) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], di_bit};
                    if (bit_cnt_q != CNT_W'(CNT_MAX)) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sc_rise) begin
                    if (bit_cnt_q < CNT_W'(DATA_WIDTH)) begin
                        do_d     = tx_rem_q[DATA_WIDTH-2];
                        tx_rem_d = {tx_rem_q[DATA_WIDTH-3:0], 1'b0};
                    end else begin
                        do_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adaptor_pic_spi_responder.sv
// Bench for adaptor_pic_spi_responder: plays the SPI initiator with directed
// frames, keeps a frame-level model of what the responder must do, and checks
// DO bits, busy, and the rx_valid / frame_err / rx_data outputs every cycle.
module tb_adaptor_pic_spi_responder;

    // SC half-period in i_clk cycles, scaled down from the 50 kHz nominal.
    localparam int unsigned HALF = 16;

    logic        i_clk       = 1'b0;
    logic        i_rst       = 1'b1;
    logic        i_PIC_SC    = 1'b1;
    logic        i_PIC_CS    = 1'b1;
    logic        i_PIC_DI    = 1'b0;
    logic        o_PIC_DO;
    logic [15:0] i_tx_data   = 16'h0000;
    logic [15:0] o_rx_data;
    logic        o_rx_valid;
    logic        o_frame_err;
    logic        o_busy;

    adaptor_pic_spi_responder dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_PIC_SC    (i_PIC_SC),
        .i_PIC_CS    (i_PIC_CS),
        .i_PIC_DI    (i_PIC_DI),
        .o_PIC_DO    (o_PIC_DO),
        .i_tx_data   (i_tx_data),
        .o_rx_data   (o_rx_data),
        .o_rx_valid  (o_rx_valid),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #4 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Frame-level model of the responder.
    bit          m_in_frame = 1'b0;
    bit          m_armed    = 1'b0;
    logic [15:0] m_tx       = 16'h0000;
    logic [15:0] m_rx       = 16'h0000;
    int          m_cnt      = 0;
    logic        m_do       = 1'b0;
    logic [15:0] last_good  = 16'h0000;
    logic [16:0] exp_q[$];     // bit 16 set: good word in [15:0]; clear: frame error
    logic [15:0] do_word    = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle output check against the model's expected event queue.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            check("pulse_overlap", 32'(o_rx_valid & o_frame_err), 32'(0));
            if (o_rx_valid) begin
                if (exp_q.size() == 0 || !exp_q[0][16]) begin
                    check("unexpected_rx_valid", 32'(o_rx_valid), 32'(0));
                end else begin
                    check("rx_data_at_valid", 32'(o_rx_data), 32'(exp_q[0][15:0]));
                    last_good = exp_q[0][15:0];
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end else begin
                if (o_frame_err) begin
                    if (exp_q.size() == 0 || exp_q[0][16]) begin
                        check("unexpected_frame_err", 32'(o_frame_err), 32'(0));
                    end
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                check("rx_data_hold", 32'(o_rx_data), 32'(last_good));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic model_fall();
        if (m_in_frame) begin
            m_rx = {m_rx[14:0], i_PIC_DI};
            if (m_cnt < 17) m_cnt++;
        end
    endtask

    task automatic model_rise();
        if (m_in_frame) m_do = (m_cnt < 16) ? m_tx[15 - m_cnt] : 1'b0;
    endtask

    task automatic cs_low(input logic [15:0] tx);
        i_tx_data = tx;
        i_PIC_CS  = 1'b0;
        if (m_armed) begin
            m_in_frame = 1'b1;
            m_tx       = tx;
            m_rx       = 16'h0000;
            m_cnt      = 0;
            m_do       = tx[15];
        end
        tick(HALF);
    endtask

    task automatic sc_fall();
        check("do_bit", 32'(o_PIC_DO), 32'(m_do));
        check("busy_in_frame", 32'(o_busy), 32'(m_in_frame));
        do_word  = {do_word[14:0], o_PIC_DO};
        i_PIC_SC = 1'b0;
        model_fall();
        tick(HALF);
    endtask

    task automatic sc_rise(input logic di, input bit glitch);
        i_PIC_SC = 1'b1;
        model_rise();
        i_PIC_DI = di;
        if (glitch) begin
            tick(5);
            i_PIC_SC = 1'b0;
`ifndef ADAPTOR_PIC_SPI_RESPONDER_FILTER_EN
            model_fall();
`endif
            tick(2);
            i_PIC_SC = 1'b1;
`ifndef ADAPTOR_PIC_SPI_RESPONDER_FILTER_EN
            model_rise();
`endif
            tick(HALF - 7);
        end else begin
            tick(HALF);
        end
    endtask

    // Ends the frame; with_sc_fall drops SC in the same instant as CS rises.
    task automatic cs_end(input bit with_sc_fall);
        if (with_sc_fall) begin
            check("do_bit_final", 32'(o_PIC_DO), 32'(m_do));
            i_PIC_SC = 1'b0;
        end
        i_PIC_CS = 1'b1;
        if (m_in_frame) exp_q.push_back((m_cnt == 16) ? {1'b1, m_rx} : 17'h0);
        m_in_frame = 1'b0;
        m_do       = 1'b0;
        m_armed    = 1'b1;
        tick(HALF);
        check("event_seen", 32'(exp_q.size()), 32'(0));
        check("busy_after_frame", 32'(o_busy), 32'(0));
        check("do_after_frame", 32'(o_PIC_DO), 32'(0));
    endtask

    task automatic frame_body(input logic [15:0] tx, input logic [15:0] rx,
                              input int nbits, input int glitch_at);
        logic [15:0] sh;
        do_word  = 16'h0000;
        i_PIC_DI = rx[15];
        cs_low(tx);
        for (int k = 0; k < nbits; k++) begin
            sc_fall();
            sh = rx << (k + 1);
            sc_rise(sh[15], k == glitch_at);
        end
    endtask

    task automatic send_frame(input logic [15:0] tx, input logic [15:0] rx, input int nbits);
        frame_body(tx, rx, nbits, -1);
        cs_end(1'b0);
    endtask

    task automatic pulse_reset();
        i_rst = 1'b1;
        tick(1);
        exp_q.delete();
        m_in_frame = 1'b0;
        m_armed    = 1'b0;
        m_cnt      = 0;
        m_do       = 1'b0;
        last_good  = 16'h0000;
        i_rst      = 1'b0;
    endtask

    initial begin
        // Power-up reset with the link idle.
        tick(4);
        check("rst_do", 32'(o_PIC_DO), 32'(0));
        check("rst_rx_data", 32'(o_rx_data), 32'(0));
        check("rst_rx_valid", 32'(o_rx_valid), 32'(0));
        check("rst_frame_err", 32'(o_frame_err), 32'(0));
        check("rst_busy", 32'(o_busy), 32'(0));
        i_rst     = 1'b0;
        last_good = 16'h0000;
        m_armed   = 1'b1;
        tick(20);

        // Nominal frame.
        send_frame(16'hA55A, 16'h3C81, 16);
        check("nominal_do_word", 32'(do_word), 32'h0000A55A);
        check("nominal_rx_data", 32'(o_rx_data), 32'h00003C81);

        // Short frame: 9 bits, previous word kept.
        send_frame(16'h0F0F, 16'hBEEF, 9);
        check("short_rx_kept", 32'(o_rx_data), 32'h00003C81);

        // Over-length frame: 18 bits, DO forced low past the 16th bit.
        send_frame(16'hFFFF, 16'h1111, 18);
        check("long_do_tail", 32'(do_word[1:0]), 32'(0));
        check("long_rx_kept", 32'(o_rx_data), 32'h00003C81);

        // Mid-frame tx change and reset with CS held low.
        do_word  = 16'h0000;
        i_PIC_DI = 1'b1;
        cs_low(16'h1234);
        for (int k = 0; k < 8; k++) begin
            sc_fall();
            sc_rise(k[0], 1'b0);
            if (k == 3) i_tx_data = 16'hFFFF;
        end
        check("mid_do_byte", 32'(do_word[7:0]), 32'h00000012);
        pulse_reset();
        check("mid_rst_busy", 32'(o_busy), 32'(0));
        check("mid_rst_rx", 32'(o_rx_data), 32'(0));
        for (int k = 0; k < 8; k++) begin
            sc_fall();
            sc_rise(k[0], 1'b0);
        end
        cs_end(1'b0);
        tick(HALF);
        send_frame(16'h5AA5, 16'hC3D2, 16);
        check("rearm_do_word", 32'(do_word), 32'h00005AA5);
        check("rearm_rx_data", 32'(o_rx_data), 32'h0000C3D2);

        // Back-to-back frames; first CS rise coincides with an SC fall.
        frame_body(16'h2468, 16'h1357, 16, -1);
        cs_end(1'b1);
        check("b2b_first_rx", 32'(o_rx_data), 32'h00001357);
        i_PIC_SC = 1'b1;
        tick(HALF);
        send_frame(16'h0001, 16'h8001, 16);
        check("b2b_second_do", 32'(do_word), 32'h00000001);
        check("b2b_second_rx", 32'(o_rx_data), 32'h00008001);

        // Two-cycle low glitch on SC during a frame.
        frame_body(16'h9C3E, 16'h6B2D, 16, 5);
        cs_end(1'b0);
`ifdef ADAPTOR_PIC_SPI_RESPONDER_FILTER_EN
        check("glitch_rx_filtered", 32'(o_rx_data), 32'h00006B2D);
`else
        check("glitch_rx_kept", 32'(o_rx_data), 32'h00008001);
`endif

        tick(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
